// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: gates the sample FIFO write enable to produce one fixed-length record per arm.
// Optional auto-trigger timeout is compiled in with `define ADC_CAPTURE_AUTO_TRIG_EN.
module adc_capture_ctrl #(
  parameter int LEN_W  = 16,
  parameter int HOLD_W = 16,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [LEN_W-1:0]  record_len,
  input  logic [HOLD_W-1:0] holdoff,
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
  input  logic [23:0]       auto_timeout,
  output logic              auto_trig,
`endif
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic [LEN_W-1:0]  words_written,
  output logic [2:0]        state
);

  // state     | meaning
  // IDLE      | waiting for arm
  // HOLDOFF   | trig ignored for the latched holdoff cycles
  // WAIT_TRIG | waiting for trig (or auto timeout)
  // CAPTURE   | one sample slot per cycle, record_len slots
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLDOFF   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  slot_cnt;
  logic [LEN_W-1:0]  slot_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              slot_last;
  logic              auto_fire;

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
  logic [23:0] wait_cnt;
  // A zero timeout loads a zero count, which never reaches the terminal value of 1.
  assign auto_fire = (state_q == S_WAIT_TRIG) && !trig && (wait_cnt == 24'd1);
`else
  assign auto_fire = 1'b0;
`endif

  assign slot_nxt   = slot_cnt + LEN_W'(1);
  assign slot_last  = (slot_nxt == len_q);
  assign fifo_wr_en = (state_q == S_CAPTURE) && !fifo_full;
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (arm) state_d = (holdoff != '0) ? S_HOLDOFF : S_WAIT_TRIG;
      S_HOLDOFF:   if (hold_cnt == HOLD_W'(1)) state_d = S_WAIT_TRIG;
      S_WAIT_TRIG: if (trig || auto_fire) state_d = S_CAPTURE;
      S_CAPTURE:   if (slot_last) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      drop_count    <= '0;
      words_written <= '0;
      len_q         <= '0;
      slot_cnt      <= '0;
      hold_cnt      <= '0;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
      wait_cnt      <= '0;
      auto_trig     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
      // Abort freezes the record statistics so software can inspect a cancelled record.
      if (!abort) begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              len_q         <= (record_len == '0) ? LEN_W'(1) : record_len;
              hold_cnt      <= holdoff;
              slot_cnt      <= '0;
              words_written <= '0;
              drop_count    <= '0;
              overflow      <= 1'b0;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
              wait_cnt      <= auto_timeout;
              auto_trig     <= 1'b0;
`endif
            end
          end
          S_HOLDOFF: hold_cnt <= hold_cnt - HOLD_W'(1);
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
          S_WAIT_TRIG: begin
            if (!trig && wait_cnt != '0) wait_cnt <= wait_cnt - 24'd1;
            if (auto_fire) auto_trig <= 1'b1;
          end
`endif
          S_CAPTURE: begin
            slot_cnt <= slot_nxt;
            if (fifo_full) begin
              overflow <= 1'b1;
              if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end else begin
              words_written <= words_written + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (default build); narrow counters make drop saturation reachable.
module tb_adc_capture_ctrl;
  localparam int LEN_W = 8, HOLD_W = 8, DROP_W = 2;

  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0, trig = 1'b0, fifo_full = 1'b0;
  logic [LEN_W-1:0]  record_len = '0;
  logic [HOLD_W-1:0] holdoff = '0;
  logic              fifo_wr_en, busy, done, overflow;
  logic [DROP_W-1:0] drop_count;
  logic [LEN_W-1:0]  words_written;
  logic [2:0]        state;
  int chk_cnt = 0, pass_cnt = 0;

  adc_capture_ctrl #(.LEN_W(LEN_W), .HOLD_W(HOLD_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .record_len(record_len), .holdoff(holdoff), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .busy(busy), .done(done), .overflow(overflow),
    .drop_count(drop_count), .words_written(words_written), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [LEN_W-1:0] len, input logic [HOLD_W-1:0] hold);
    record_len = len;
    holdoff    = hold;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    chk_cnt++;
    if ({state, fifo_wr_en, busy, done, overflow, drop_count, words_written} !== '0)
      $display("FAIL reset_outputs: got st=%0d we=%0d busy=%0d done=%0d ovf=%0d drop=%0d words=%0d want all 0",
               state, fifo_wr_en, busy, done, overflow, drop_count, words_written);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    chk_cnt++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL reset_release: got st=%0d busy=%0d want 0 0", state, busy);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    do_arm(8'd8, 8'd0);
    chk_cnt++;
    if (state !== 3'd2 || busy !== 1'b1) $display("FAIL basic_wait_entry: got st=%0d busy=%0d want 2 1", state, busy);
    else pass_cnt++;
    repeat (4) begin
      chk_cnt++;
      if (state !== 3'd2 || fifo_wr_en !== 1'b0) $display("FAIL basic_waiting: got st=%0d we=%0d want 2 0", state, fifo_wr_en);
      else pass_cnt++;
      tick();
    end
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (state !== 3'd3 || fifo_wr_en !== 1'b1) $display("FAIL basic_capture_%0d: got st=%0d we=%0d want 3 1", i, state, fifo_wr_en);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (state !== 3'd4 || done !== 1'b1 || fifo_wr_en !== 1'b0 || words_written !== 8'd8 || overflow !== 1'b0 || drop_count !== 2'd0)
      $display("FAIL basic_done: got st=%0d done=%0d we=%0d words=%0d ovf=%0d drop=%0d want 4 1 0 8 0 0",
               state, done, fifo_wr_en, words_written, overflow, drop_count);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle: got st=%0d done=%0d busy=%0d want 0 0 0", state, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_holdoff;
    trig = 1'b1;
    do_arm(8'd2, 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (state !== 3'd1 || fifo_wr_en !== 1'b0) $display("FAIL holdoff_cycle_%0d: got st=%0d we=%0d want 1 0", i, state, fifo_wr_en);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (state !== 3'd2 || fifo_wr_en !== 1'b0) $display("FAIL holdoff_wait: got st=%0d we=%0d want 2 0", state, fifo_wr_en);
    else pass_cnt++;
    tick();
    trig = 1'b0;
    chk_cnt++;
    if (state !== 3'd3 || fifo_wr_en !== 1'b1) $display("FAIL holdoff_capture: got st=%0d we=%0d want 3 1", state, fifo_wr_en);
    else pass_cnt++;
    repeat (2) tick();
    chk_cnt++;
    if (state !== 3'd4 || words_written !== 8'd2) $display("FAIL holdoff_done: got st=%0d words=%0d want 4 2", state, words_written);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fifo_full;
    logic exp_we;
    do_arm(8'd10, 8'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      fifo_full = (i >= 3 && i <= 5);
      exp_we    = !(i >= 3 && i <= 5);
      #1;
      chk_cnt++;
      if (fifo_wr_en !== exp_we || state !== 3'd3) $display("FAIL full_slot_%0d: got we=%0d st=%0d want %0d 3", i, fifo_wr_en, state, exp_we);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (state !== 3'd4 || done !== 1'b1 || words_written !== 8'd7 || drop_count !== 2'd3 || overflow !== 1'b1)
      $display("FAIL full_done: got st=%0d done=%0d words=%0d drop=%0d ovf=%0d want 4 1 7 3 1",
               state, done, words_written, drop_count, overflow);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_saturate;
    do_arm(8'd6, 8'd0);
    fifo_full = 1'b1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (6) begin
      chk_cnt++;
      if (fifo_wr_en !== 1'b0) $display("FAIL sat_no_write: got we=%0d want 0", fifo_wr_en);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (state !== 3'd4 || drop_count !== 2'd3 || words_written !== 8'd0 || overflow !== 1'b1)
      $display("FAIL sat_done: got st=%0d drop=%0d words=%0d ovf=%0d want 4 3 0 1", state, drop_count, words_written, overflow);
    else pass_cnt++;
    fifo_full = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    do_arm(8'd16, 8'd0);
    chk_cnt++;
    if (overflow !== 1'b0 || drop_count !== 2'd0 || words_written !== 8'd0)
      $display("FAIL abort_arm_clear: got ovf=%0d drop=%0d words=%0d want 0 0 0", overflow, drop_count, words_written);
    else pass_cnt++;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_cnt++;
    if (state !== 3'd0 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || words_written !== 8'd4)
      $display("FAIL abort_idle: got st=%0d we=%0d busy=%0d done=%0d words=%0d want 0 0 0 0 4",
               state, fifo_wr_en, busy, done, words_written);
    else pass_cnt++;
    repeat (3) begin
      chk_cnt++;
      if (done !== 1'b0 || state !== 3'd0) $display("FAIL abort_no_done: got done=%0d st=%0d want 0 0", done, state);
      else pass_cnt++;
      tick();
    end
    do_arm(8'd3, 8'd0);
    chk_cnt++;
    if (words_written !== 8'd0 || state !== 3'd2) $display("FAIL abort_rearm: got words=%0d st=%0d want 0 2", words_written, state);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_cnt++;
    if (state !== 3'd0) $display("FAIL abort_from_wait: got st=%0d want 0", state);
    else pass_cnt++;
  endtask

  task automatic test_edges;
    do_arm(8'd0, 8'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk_cnt++;
    if (state !== 3'd3 || fifo_wr_en !== 1'b1) $display("FAIL len0_capture: got st=%0d we=%0d want 3 1", state, fifo_wr_en);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (state !== 3'd4 || done !== 1'b1 || words_written !== 8'd1 || fifo_wr_en !== 1'b0)
      $display("FAIL len0_done: got st=%0d done=%0d words=%0d we=%0d want 4 1 1 0", state, done, words_written, fifo_wr_en);
    else pass_cnt++;
    tick();

    do_arm(8'd4, 8'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    arm = 1'b1;
    record_len = 8'd1;
    repeat (4) begin
      chk_cnt++;
      if (state !== 3'd3 || fifo_wr_en !== 1'b1) $display("FAIL arm_in_capture: got st=%0d we=%0d want 3 1", state, fifo_wr_en);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if (state !== 3'd4 || done !== 1'b1 || words_written !== 8'd4)
      $display("FAIL arm_capture_done: got st=%0d done=%0d words=%0d want 4 1 4", state, done, words_written);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL arm_in_done: got st=%0d busy=%0d want 0 0", state, busy);
    else pass_cnt++;
    tick();
    arm = 1'b0;
    chk_cnt++;
    if (state !== 3'd2 || busy !== 1'b1) $display("FAIL rearm_latency: got st=%0d busy=%0d want 2 1", state, busy);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    do_arm(8'd8, 8'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    chk_cnt++;
    if (state !== 3'd3 || words_written !== 8'd1) $display("FAIL pre_rst_capture: got st=%0d words=%0d want 3 1", state, words_written);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({state, fifo_wr_en, busy, done, overflow, drop_count, words_written} !== '0)
      $display("FAIL async_rst: got st=%0d we=%0d busy=%0d done=%0d ovf=%0d drop=%0d words=%0d want all 0",
               state, fifo_wr_en, busy, done, overflow, drop_count, words_written);
    else pass_cnt++;
    #1 rst = 1'b0;
    tick();
    chk_cnt++;
    if (state !== 3'd0 || fifo_wr_en !== 1'b0) $display("FAIL post_rst_idle: got st=%0d we=%0d want 0 0", state, fifo_wr_en);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_holdoff();
    test_fifo_full();
    test_saturate();
    test_abort();
    test_edges();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
